// File: rtl/mc14500b_seq_if.sv
// Sequencer bus: program-memory fetch port, ICU instruction/address outputs and ICU flag inputs.
// master = sequencer side, slave = memory/ICU/system side.
interface mc14500b_seq_if #(
    parameter int AW = 8
);
    logic          start;
    logic [AW+3:0] prog_data;
    logic          jmp;
    logic          rtn;
    logic          flg0;
    logic          flgf;
    logic [AW-1:0] prog_addr;
    logic [3:0]    instr;
    logic [AW-1:0] io_addr;
    logic          halted;
    logic          err;

    modport master (
        input  start, prog_data, jmp, rtn, flg0, flgf,
        output prog_addr, instr, io_addr, halted, err
    );

    modport slave (
        output start, prog_data, jmp, rtn, flg0, flgf,
        input  prog_addr, instr, io_addr, halted, err
    );
endinterface

// File: rtl/mc14500b_seq.sv
// MC14500B program sequencer: PC, fetch, call/return and halt/restart. Optional return stack: MC14500B_SEQ_STACK_EN.
// Latency: prog_addr combinational; instr/io_addr one edge after fetch; redirect two edges after the flagging word.
// Backpressure: none; one word per RUN edge, HALT stuffs NOPF until start.
module mc14500b_seq #(
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mc14500b_seq_if.master bus
);
    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ign_q, ign_d;
    logic          run_fetch;
    logic [AW-1:0] pc_q, fa, rtn_addr;
    logic [AW-1:0] fa_d1, fa_d2, fld_d1, fld_d2;
    logic [3:0]    instr_q;
    logic [AW-1:0] io_addr_q;
    logic          call_pending;
    logic          err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            ign_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ign_q   <= ign_d;
        end
    end

    // A halting FLGF edge takes the whole cycle: no fetch, no stack activity.
    always_comb begin
        state_d   = state_q;
        ign_d     = ign_q;
        run_fetch = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.flgf && (ign_q == 2'd0)) begin
                    state_d = ST_HALT;
                end else begin
                    run_fetch = 1'b1;
                    if (ign_q != 2'd0) ign_d = ign_q - 2'd1;
                end
            end
            ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    ign_d   = 2'd2;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        fa = pc_q;
        if (state_q == ST_RUN) begin
            if (bus.jmp)      fa = fld_d2;
            else if (bus.rtn) fa = rtn_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            instr_q   <= 4'h0;
            io_addr_q <= '0;
            fa_d1     <= '0;
            fa_d2     <= '0;
            fld_d1    <= '0;
            fld_d2    <= '0;
        end else if (run_fetch) begin
            instr_q   <= bus.prog_data[AW+3:AW];
            io_addr_q <= bus.prog_data[AW-1:0];
            pc_q      <= fa + AW'(1);
            fa_d1     <= fa;
            fa_d2     <= fa_d1;
            fld_d1    <= bus.prog_data[AW-1:0];
            fld_d2    <= fld_d1;
        end else begin
            instr_q   <= 4'hF;
            io_addr_q <= '0;
        end
    end

`ifdef MC14500B_SEQ_STACK_EN
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [AW-1:0] stk [STACK_DEPTH];
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] top_idx, push_idx;
    logic          do_push, do_pop, full, empty;

    assign full     = (cnt_q == CW'(STACK_DEPTH));
    assign empty    = (cnt_q == '0);
    assign top_idx  = IW'(cnt_q - CW'(1));
    assign push_idx = IW'(cnt_q);
    assign rtn_addr = empty ? '0 : stk[top_idx];
    // JMP beats RTN: a simultaneous pair never pops.
    assign do_push  = run_fetch && bus.jmp && call_pending;
    assign do_pop   = run_fetch && !bus.jmp && bus.rtn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            call_pending <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            call_pending <= run_fetch && bus.flg0;
            if (do_push) begin
                if (full) err_q <= 1'b1;
                else      cnt_q <= cnt_q + CW'(1);
            end else if (do_pop) begin
                if (empty) err_q <= 1'b1;
                else       cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    // fa_d1 is the word after the JMP, i.e. the return point.
    always_ff @(posedge clk) begin
        if (do_push && !full) stk[push_idx] <= fa_d1;
    end

    logic unused_hist;
    assign unused_hist = &{1'b0, fa_d2};
`else
    assign call_pending = 1'b0;
    assign err_q        = 1'b0;
    assign rtn_addr     = '0;

    logic unused_nostack;
    assign unused_nostack = &{1'b0, bus.flg0, fa_d1, fa_d2, call_pending};
`endif

    assign bus.prog_addr = fa;
    assign bus.instr     = instr_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.err       = err_q;
endmodule

// File: doc/mc14500b_seq.md
# mc14500b_seq

Program sequencer feeding the mc14500b ICU. Owns the program counter, drives the program-memory address, and registers each fetched word onto the ICU's `INSTR` input and the I/O address bus. Consumes the ICU's `JMP`, `RTN`, `FLG0` and `FLGF` pulses to redirect flow, run call/return, and halt/restart.

## Interface

- `AW`, 8: PC / address-field width; program word is `{opcode[3:0], field[AW-1:0]}`.
- `STACK_DEPTH`, 4: return-stack entries, minimum 1. Used only with the stack feature.

- `CLK` in 1: sequencer clock. The system ties ICU `X2 = ~CLK`.
- `RST_N` in 1: reset, asynchronous and active-low.
- `START` in 1: one-cycle pulse that leaves HALT.
- `PROG_DATA` in 4+AW: program word at `PROG_ADDR`, asynchronous-read memory.
- `JMP`, `RTN`, `FLG0`, `FLGF` in 1 each: ICU flag outputs.
- `PROG_ADDR` out AW: combinational fetch address.
- `INSTR` out 4: registered opcode to the ICU.
- `IO_ADDR` out AW: registered address field, selects the ICU `DATA_IN`/`DATA_OUT` target.
- `HALTED` out 1: high in HALT.
- `ERR` out 1: sticky stack overflow/underflow.

## Operation

- **State.**
  - PC.
  - Two-deep fetch history: `fa_d1`/`fa_d2` hold fetch addresses; `fld_d1`/`fld_d2` hold address fields.
  - `call_pending`.
  - Return stack with count.
  - FSM {RUN, HALT}.
  - `ign_cnt` (2 bits).
- **Fetch address `fa`, in priority order:**
  - HALT: PC.
  - `JMP`: `fld_d2`, the field of the JMP word.
  - `RTN`: the popped stack top.
  - otherwise: PC.
  - `PROG_ADDR = fa`.
- **Each RUN edge:**
  - `INSTR <= PROG_DATA[AW+3:AW]`, `IO_ADDR <= PROG_DATA[AW-1:0]`.
  - `PC <= fa + 1`, modulo 2^AW (wraps 2^AW−1 → 0).
  - History shifts.
- **Call.**
  - `FLG0` sampled high sets `call_pending` for exactly the next edge.
  - `JMP` with `call_pending` pushes `fa_d1`, the address of the word after the JMP.
  - A plain JMP does not push.
- **RTN.** Pops the stack. Empty stack: `fa = 0`, `ERR <= 1`.
- **Overflow.** A push at full drops the entry, sets `ERR`, and the jump still occurs.
- **Simultaneous `JMP` and `RTN`.** `JMP` wins. No pop; a push occurs if a call is pending.
- **Skipped word.** The word fetched on the edge where the ICU asserts `JMP`/`RTN` is skipped by the ICU. The sequencer issues it unmodified.
- **FLGF.** Sampled high in RUN with `ign_cnt == 0`: go to HALT and hold PC.
- **HALT.**
  - `INSTR <= 4'hF` (NOPF), `IO_ADDR <= 0`. `JMP`/`RTN`/`FLG0`/`FLGF` are ignored.
  - `START` → RUN with `ign_cnt <= 2`. FLGF is ignored while `ign_cnt != 0`, which decrements each edge, so stuffed-NOPF echoes cannot re-halt.
  - RUN resumes fetching at the held PC.
- **Reset (asynchronous, `RST_N` low):**
  - PC = 0, `INSTR` = 0, `IO_ADDR` = 0.
  - History = 0, stack empty, `call_pending` = 0.
  - FSM = RUN, `ign_cnt` = 0, `HALTED` = 0, `ERR` = 0.
  - Reset mid-call discards the stack. The first edge after release fetches address 0.

## Timing

- Edge k: word at address p is fetched onto `INSTR`. ICU latches it at the `CLK` falling edge and executes it at edge k+1, where its flags rise.
- Sequencer samples flags at edge k+2. Redirected fetch occurs at k+2. The word at p+1, fetched at k+1, is skipped by the ICU.
- Redirect latency is 2 edges. No extra bubble.
- Flags are pulses one `CLK` period wide, stable at the sampling edge.
- `PROG_ADDR` settles combinationally within the cycle. Memory read must fit the half-cycle to the edge.

## Configuration

- `MC14500B_SEQ_STACK_EN` defined:
  - return stack, call detection and `ERR` as above.
- Not defined:
  - no stack, and `FLG0` is ignored.
  - `RTN` always sets `fa = 0` (program restart loop).
  - `ERR` is tied 0.

## Test plan

- Reset, then 5 edges with no flags → `PROG_ADDR` 0,1,2,3,4. `INSTR`/`IO_ADDR` follow the words at those addresses, one edge later.
- Word at 0x10 = JMP with field 0x40; force `JMP` at the matching edge → fetch sequence …0x10, 0x11, 0x40, 0x41. Stack unchanged.
- NOP0 at 0x20, JMP 0x80 at 0x21, RTN at 0x82, with matching flags → sequence 0x80, 0x81, 0x82, 0x83, 0x22, 0x23. `ERR` = 0.
- RTN with empty stack → fetch 0x00, `ERR` = 1 and sticky until reset. Five nested calls with `STACK_DEPTH` = 4 → `ERR` = 1.
- NOPF at 0x30 → `HALTED` = 1, `INSTR` = F, PC frozen at 0x32. `START` → 0x32 fetched next. FLGF echoes during `ign_cnt` do not re-halt.
- Assert `RST_N` low mid-call, with 2 entries pushed → all outputs at reset values immediately. After release, fetch 0x00 and the stack is empty.
